// File: rtl/ps2_hex_word_loader_pkg.sv
// ps2_loader_pkg: shared definitions for the PS/2 hex word loader.
//   - PS/2 set-2 scan codes for the prefixes and editing keys
//   - loader FSM state type
//   - word-index names for the TEA load order (v0, v1, k0..k3)
package ps2_loader_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [2:0] IDX_V0 = 3'd0;
  localparam logic [2:0] IDX_V1 = 3'd1;
  localparam logic [2:0] IDX_K0 = 3'd2;
  localparam logic [2:0] IDX_K1 = 3'd3;
  localparam logic [2:0] IDX_K2 = 3'd4;
  localparam logic [2:0] IDX_K3 = 3'd5;

endpackage

// File: rtl/ps2_hex_word_loader_if.sv
// ps2_hex_word_loader_if: valid/ready word channel from the loader to the
// crypt control.
//   word_out   : assembled W-bit word
//   word_index : which word of the load sequence (0=v0, 1=v1, 2..5=k0..k3)
//   word_valid : word_out/word_index valid
//   word_ready : consumer accepts the word
// Modports: master (loader side), slave (consumer side).
interface ps2_hex_word_loader_if #(
  parameter int W = 32
);
  logic [W-1:0] word_out;
  logic [2:0]   word_index;
  logic         word_valid;
  logic         word_ready;

  modport master (
    output word_out,
    output word_index,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_index,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/ps2_hex_word_loader_decode.sv
// ps2_hex_decode: purely combinational map from a PS/2 set-2 make code to a
// hex nibble.
//   scan_code in  8  byte from the keyboard receiver
//   is_hex    out 1  scan_code is one of the 16 hex-digit make codes
//   nibble    out 4  digit value (0 when is_hex is low)
module ps2_hex_decode (
  input  logic [7:0] scan_code,
  output logic       is_hex,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex = 1'b1;
    nibble = 4'h0;
    case (scan_code)
      8'h45:   nibble = 4'h0;
      8'h16:   nibble = 4'h1;
      8'h1E:   nibble = 4'h2;
      8'h26:   nibble = 4'h3;
      8'h25:   nibble = 4'h4;
      8'h2E:   nibble = 4'h5;
      8'h36:   nibble = 4'h6;
      8'h3D:   nibble = 4'h7;
      8'h3E:   nibble = 4'h8;
      8'h46:   nibble = 4'h9;
      8'h1C:   nibble = 4'hA;
      8'h32:   nibble = 4'hB;
      8'h21:   nibble = 4'hC;
      8'h23:   nibble = 4'hD;
      8'h24:   nibble = 4'hE;
      8'h2B:   nibble = 4'hF;
      default: is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_hex_word_loader.sv
// ps2_hex_word_loader: turns PS/2 hex-digit keystrokes into full-width words
// and hands them, in order (v0, v1, k0..k3), to the TEA crypt control over a
// valid/ready channel.
//
// Ports:
//   clk         in   1  system clock
//   resetn      in   1  asynchronous, active-low reset
//   scan_code   in   8  PS/2 byte from keyboard receiver
//   scan_valid  in   1  one-cycle strobe, scan_code valid
//   word_bus    master  word_out / word_index / word_valid / word_ready
//   all_loaded  out  1  one-cycle pulse after the last word is accepted
//   preview     out  W  live digit accumulator (for HEX display)
//   digit_count out  4  digits currently entered, 0..DIGITS
//   overflow    out  1  sticky: a digit arrived with the accumulator full
//
// Build option: define HEX_LOADER_AUTOCOMMIT_EN to commit a word as soon as
// its last digit is typed (overflow then never sets). Without it only Enter
// commits.
module ps2_hex_word_loader
  import ps2_loader_pkg::*;
#(
  parameter  int NUM_WORDS = 6,
  parameter  int DIGITS    = 8,
  localparam int W         = 4 * DIGITS
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [7:0]                   scan_code,
  input  logic                         scan_valid,
  ps2_hex_word_loader_if.master        word_bus,
  output logic                         all_loaded,
  output logic [W-1:0]                 preview,
  output logic [3:0]                   digit_count,
  output logic                         overflow
);

  localparam logic [3:0] DIGITS_C = 4'(DIGITS);
  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

  state_t       state_reg, state_next;
  logic [W-1:0] acc_reg, acc_next;
  logic [W-1:0] word_reg, word_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic [2:0]   idx_reg, idx_next;
  logic         ovf_reg, ovf_next;
  logic         brk_reg, brk_next;
  logic         ext_reg, ext_next;
  logic         loaded_reg, loaded_next;

  logic         is_hex;
  logic [3:0]   nibble;
  logic         take;
  logic         is_prefix;
  logic         live;
  logic         enter_commit;
  logic         auto_commit;
  logic         do_commit;
  logic         transfer;

  ps2_hex_decode u_decode (
    .scan_code (scan_code),
    .is_hex    (is_hex),
    .nibble    (nibble)
  );

  // Event decode. Bytes are only looked at while collecting; in PRESENT
  // everything (prefixes included) is dropped and the prefix flags hold.
  always_comb begin
    take         = scan_valid && (state_reg == COLLECT);
    is_prefix    = (scan_code == SC_BREAK) || (scan_code == SC_EXT);
    // A byte following a break/extended prefix is swallowed, not acted on.
    live         = take && !is_prefix && !brk_reg && !ext_reg;
    enter_commit = live && (scan_code == SC_ENTER);
`ifdef HEX_LOADER_AUTOCOMMIT_EN
    auto_commit  = live && is_hex && (cnt_reg == DIGITS_C - 4'd1);
`else
    auto_commit  = 1'b0;
`endif
    do_commit    = enter_commit || auto_commit;
    transfer     = (state_reg == PRESENT) && word_bus.word_ready;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (do_commit) state_next = PRESENT;
      PRESENT: if (transfer)  state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    word_bus.word_valid = (state_reg == PRESENT);
    word_bus.word_out   = word_reg;
    word_bus.word_index = idx_reg;
    all_loaded          = loaded_reg;
    preview             = acc_reg;
    digit_count         = cnt_reg;
    overflow            = ovf_reg;
  end

  // Datapath next-state
  always_comb begin
    acc_next    = acc_reg;
    word_next   = word_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    ovf_next    = ovf_reg;
    brk_next    = brk_reg;
    ext_next    = ext_reg;
    loaded_next = 1'b0;

    if (take) begin
      if (scan_code == SC_BREAK) begin
        brk_next = 1'b1;
      end else if (scan_code == SC_EXT) begin
        ext_next = 1'b1;
      end else if (brk_reg || ext_reg) begin
        // Swallow the released/extended key and reset the prefix tracker.
        brk_next = 1'b0;
        ext_next = 1'b0;
      end else if (is_hex) begin
        if (cnt_reg < DIGITS_C) begin
          acc_next = {acc_reg[W-5:0], nibble};
          cnt_next = cnt_reg + 4'd1;
`ifdef HEX_LOADER_AUTOCOMMIT_EN
          if (auto_commit) begin
            word_next = {acc_reg[W-5:0], nibble};
            acc_next  = '0;
            cnt_next  = 4'd0;
            ovf_next  = 1'b0;
          end
`else
`endif
        end else begin
`ifdef HEX_LOADER_AUTOCOMMIT_EN
          // Unreachable: the word commits before the accumulator fills.
          ovf_next = ovf_reg;
`else
          ovf_next = 1'b1;
`endif
        end
      end else begin
        case (scan_code)
          SC_BKSP: begin
            if (cnt_reg != 4'd0) begin
              acc_next = acc_reg >> 4;
              cnt_next = cnt_reg - 4'd1;
            end
          end
          SC_ESC: begin
            acc_next = '0;
            cnt_next = 4'd0;
            ovf_next = 1'b0;
          end
          SC_ENTER: begin
            word_next = acc_reg;
            acc_next  = '0;
            cnt_next  = 4'd0;
            ovf_next  = 1'b0;
          end
          default: ;
        endcase
      end
    end

    if (transfer) begin
      if (idx_reg == LAST_IDX) begin
        idx_next    = IDX_V0;
        loaded_next = 1'b1;
      end else begin
        idx_next = idx_reg + 3'd1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_reg    <= '0;
      word_reg   <= '0;
      cnt_reg    <= 4'd0;
      idx_reg    <= IDX_V0;
      ovf_reg    <= 1'b0;
      brk_reg    <= 1'b0;
      ext_reg    <= 1'b0;
      loaded_reg <= 1'b0;
    end else begin
      acc_reg    <= acc_next;
      word_reg   <= word_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      ovf_reg    <= ovf_next;
      brk_reg    <= brk_next;
      ext_reg    <= ext_next;
      loaded_reg <= loaded_next;
    end
  end

endmodule
